// File: rtl/tea_stream_core.sv
// TEA/XTEA block cipher engine with valid/ready streaming on both sides.
// Each clock in RUN performs UNROLL half-rounds; the result is presented in DONE until taken.
module tea_stream_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [63:0]  i_data,
  input  logic [127:0] i_key,
  input  logic         i_dec,
  input  logic         i_xtea,
  input  logic         i_abort,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [63:0]  o_data
);

  if (ROUNDS == 0) begin : g_bad_rounds
    $error("tea_stream_core: ROUNDS must be >= 1");
  end
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("tea_stream_core: UNROLL must be 1 or 2");
  end

  localparam int unsigned H  = (UNROLL == 2) ? ROUNDS : 2 * ROUNDS;
  localparam int unsigned CW = $clog2(H + 1);
  localparam logic [CW-1:0] LAST    = CW'(H - 1);
  localparam logic [31:0]   DEC_SUM = 32'(DELTA * ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0]    key_q, key_d;
  logic            dec_q, dec_d, xtea_q, xtea_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     odata_q, odata_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] a_v0, a_v1, a_sum;
  logic [31:0] bi_v0, bi_v1, bi_sum;
  logic [31:0] b_v0, b_v1, b_sum;
  logic [31:0] st_v0, st_v1, st_sum;

  function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] ka,
                                        input logic [31:0] kb, input logic [31:0] s);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  function automatic logic [31:0] xtea_f(input logic [31:0] v, input logic [31:0] s,
                                         input logic [31:0] kx);
    return (((v << 4) ^ (v >> 5)) + v) ^ (s + kx);
  endfunction

  function automatic logic [31:0] kw(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    return k[127:96];
      2'd1:    return k[95:64];
      2'd2:    return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  always_comb begin : half_a
    a_v0  = v0_q;
    a_v1  = v1_q;
    a_sum = sum_q;
    case ({xtea_q, dec_q})
      2'b00: begin
        a_sum = sum_q + DELTA;
        a_v0  = v0_q + tea_f(v1_q, k0, k1, a_sum);
      end
      2'b01: a_v1 = v1_q - tea_f(v0_q, k2, k3, sum_q);
      2'b10: a_v0 = v0_q + xtea_f(v1_q, sum_q, kw(key_q, sum_q[1:0]));
      default: begin
        a_v1  = v1_q - xtea_f(v0_q, sum_q, kw(key_q, sum_q[12:11]));
        a_sum = sum_q - DELTA;
      end
    endcase
  end

  // With UNROLL=2 half B consumes half A's result in the same clock.
  always_comb begin : half_b
    if (UNROLL == 2) begin
      bi_v0 = a_v0;  bi_v1 = a_v1;  bi_sum = a_sum;
    end else begin
      bi_v0 = v0_q;  bi_v1 = v1_q;  bi_sum = sum_q;
    end
    b_v0  = bi_v0;
    b_v1  = bi_v1;
    b_sum = bi_sum;
    case ({xtea_q, dec_q})
      2'b00: b_v1 = bi_v1 + tea_f(bi_v0, k2, k3, bi_sum);
      2'b01: begin
        b_v0  = bi_v0 - tea_f(bi_v1, k0, k1, bi_sum);
        b_sum = bi_sum - DELTA;
      end
      2'b10: begin
        b_sum = bi_sum + DELTA;
        b_v1  = bi_v1 + xtea_f(bi_v0, b_sum, kw(key_q, b_sum[12:11]));
      end
      default: b_v0 = bi_v0 - xtea_f(bi_v1, bi_sum, kw(key_q, bi_sum[1:0]));
    endcase
  end

  always_comb begin : step_sel
    if (UNROLL == 2 || count_q[0]) begin
      st_v0 = b_v0;  st_v1 = b_v1;  st_sum = b_sum;
    end else begin
      st_v0 = a_v0;  st_v1 = a_v1;  st_sum = a_sum;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    key_d   = key_q;
    dec_d   = dec_q;
    xtea_d  = xtea_q;
    count_d = count_q;
    odata_d = odata_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_RUN;
          v0_d    = i_data[63:32];
          v1_d    = i_data[31:0];
          key_d   = i_key;
          dec_d   = i_dec;
          xtea_d  = i_xtea;
          sum_d   = i_dec ? DEC_SUM : '0;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          v0_d    = st_v0;
          v1_d    = st_v1;
          sum_d   = st_sum;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = S_DONE;
            odata_d = {st_v0, st_v1};
          end
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      xtea_q  <= 1'b0;
      count_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      xtea_q  <= xtea_d;
      count_q <= count_d;
      odata_q <= odata_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_data  = odata_q;

endmodule

// File: tb/tb_tea_stream_core.sv
// Scoreboard bench: four core configurations share stimulus; a C-style cipher model
// supplies expected blocks, and per-instance monitors pop and compare on each handshake.
module tb_tea_stream_core;

  localparam int NC = 4;
  localparam int unsigned RT [NC] = '{32, 32, 8, 1};
  localparam int unsigned UT [NC] = '{1, 2, 2, 1};
  localparam logic [31:0]   DELTA = 32'h9E3779B9;
  localparam logic [NC-1:0] ALL   = '1;
  localparam logic [63:0]   TEA0  = 64'h41EA3A0A_94BAA940;
  localparam logic [63:0]   XTEA0 = 64'hDEE9D4D8_F7131ED9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, i_valid, i_dec, i_xtea, i_abort, i_ready;
  logic [127:0]  i_key;
  logic [63:0]   din  [NC];
  logic [63:0]   dout [NC];
  logic [NC-1:0] rdy, vld;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic [63:0] exp_q [NC][$];
  int          acc_q [NC][$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned h_of(input int g);
    return 2 * RT[g] / UT[g];
  endfunction

  // Reference encryption written as the classic C loops.
  function automatic logic [63:0] ref_enc(input logic [63:0] d, input logic [127:0] k,
                                          input bit xt, input int unsigned rounds);
    logic [31:0] v0, v1, sum;
    logic [31:0] kk [4];
    v0 = d[63:32];
    v1 = d[31:0];
    sum = 32'd0;
    for (int i = 0; i < 4; i++) kk[i] = k[127 - 32*i -: 32];
    for (int unsigned r = 0; r < rounds; r++) begin
      if (!xt) begin
        sum = sum + DELTA;
        v0 = v0 + (((v1 << 4) + kk[0]) ^ (v1 + sum) ^ ((v1 >> 5) + kk[1]));
        v1 = v1 + (((v0 << 4) + kk[2]) ^ (v0 + sum) ^ ((v0 >> 5) + kk[3]));
      end else begin
        v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kk[int'(sum & 32'd3)]));
        sum = sum + DELTA;
        v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kk[int'((sum >> 11) & 32'd3)]));
      end
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (rdy != ALL && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(rdy), 64'(ALL));
  endtask

  task automatic send(input logic [63:0] pt, input logic [127:0] key, input bit dec,
                      input bit xt, input logic [NC-1:0] mask, input bit use_known,
                      input logic [63:0] known);
    logic [63:0] ct [NC];
    wait_all_ready();
    for (int g = 0; g < NC; g++) begin
      ct[g]  = ref_enc(pt, key, xt, RT[g]);
      din[g] = dec ? ct[g] : pt;
    end
    i_key   = key;
    i_dec   = dec;
    i_xtea  = xt;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int g = 0; g < NC; g++) begin
      if (mask[g]) begin
        if (dec)                         exp_q[g].push_back(pt);
        else if (use_known && RT[g] == 32) exp_q[g].push_back(known);
        else                             exp_q[g].push_back(ct[g]);
        acc_q[g].push_back(cyc);
      end
    end
  endtask

  function automatic bit all_empty();
    for (int g = 0; g < NC; g++) if (exp_q[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while (!all_empty() && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(all_empty()), 64'd1);
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_dut
    tea_stream_core #(.ROUNDS(RT[g]), .UNROLL(UT[g])) u_dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_valid (i_valid),
      .o_ready (rdy[g]),
      .i_data  (din[g]),
      .i_key   (i_key),
      .i_dec   (i_dec),
      .i_xtea  (i_xtea),
      .i_abort (i_abort),
      .o_valid (vld[g]),
      .i_ready (i_ready),
      .o_data  (dout[g])
    );

    initial begin : mon
      logic pv;
      logic [63:0] e;
      pv = 1'b0;
      forever begin
        @(negedge clk);
        if (vld[g] && !pv) begin
          if (acc_q[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid[%0d]: got o_valid=1 expected 0", g);
          end else begin
            chk($sformatf("latency[%0d]", g), 64'(cyc - acc_q[g][0]), 64'(h_of(g)));
          end
        end
        pv = vld[g];
        if (vld[g] && i_ready) begin
          if (exp_q[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output[%0d]: got %h expected none", g, dout[g]);
          end else begin
            e = exp_q[g].pop_front();
            void'(acc_q[g].pop_front());
            chk($sformatf("data[%0d]", g), dout[g], e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rand_ready) begin
        #1;
        i_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [63:0]   pt;
    logic [127:0]  key;
    bit            xt;
    logic [NC-1:0] mask;
    int            n;

    rstn = 1'b0; i_valid = 1'b0; i_dec = 1'b0; i_xtea = 1'b0;
    i_abort = 1'b0; i_ready = 1'b1; i_key = '0;
    for (int g = 0; g < NC; g++) din[g] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NC; g++) chk($sformatf("reset_data[%0d]", g), dout[g], 64'd0);
    chk("reset_valid", 64'(vld), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 64'(rdy), 64'(ALL));

    // Known all-zero vectors
    send(64'd0, 128'd0, 1'b0, 1'b0, ALL, 1'b1, TEA0);
    drain();
    send(64'd0, 128'd0, 1'b0, 1'b1, ALL, 1'b1, XTEA0);
    drain();

    // Random encrypt / decrypt round trips with random downstream stalls
    rand_ready = 1'b1;
    repeat (120) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      xt  = 1'($urandom_range(0, 1));
      send(pt, key, 1'b0, xt, ALL, 1'b0, 64'd0);
      send(pt, key, 1'b1, xt, ALL, 1'b0, 64'd0);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    i_ready = 1'b1;

    // Backpressure: result held, core busy, extra i_valid ignored
    i_ready = 1'b0;
    pt  = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    send(pt, key, 1'b0, 1'b1, ALL, 1'b0, 64'd0);
    n = 0;
    while (vld != ALL && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_all_valid", 64'(vld), 64'(ALL));
    i_valid = 1'b1;
    for (int g = 0; g < NC; g++) din[g] = ~din[g];
    repeat (10) begin
      @(posedge clk); #1;
      for (int g = 0; g < NC; g++)
        if (exp_q[g].size() != 0) chk($sformatf("bp_data[%0d]", g), dout[g], exp_q[g][0]);
      chk("bp_ready", 64'(rdy), 64'd0);
      chk("bp_valid", 64'(vld), 64'(ALL));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 64'(rdy), 64'(ALL));
    drain();
    repeat (80) @(posedge clk);
    #1;

    // Abort at count=5: only configurations already finished deliver a result
    mask = '0;
    for (int g = 0; g < NC; g++) if (h_of(g) <= 5) mask[g] = 1'b1;
    send(64'd0, 128'd0, 1'b0, 1'b0, mask, 1'b1, TEA0);
    repeat (5) @(posedge clk);
    #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("abort_ready", 64'(rdy), 64'(ALL));
    send(64'd0, 128'd0, 1'b0, 1'b0, ALL, 1'b1, TEA0);
    drain();

    // Asynchronous reset at count=20
    mask = '0;
    for (int g = 0; g < NC; g++) if (h_of(g) < 20) mask[g] = 1'b1;
    pt  = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    send(pt, key, 1'b0, 1'b0, mask, 1'b0, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_valid", 64'(vld), 64'd0);
    for (int g = 0; g < NC; g++) chk($sformatf("rst_data[%0d]", g), dout[g], 64'd0);
    for (int g = 0; g < NC; g++) begin
      exp_q[g].delete();
      acc_q[g].delete();
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    send(pt, key, 1'b0, 1'b1, ALL, 1'b0, 64'd0);
    drain();

    repeat (80) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
